run_sequencer: RTL



---
 rtl/run_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/run_sequencer.sv
// Run-control and program counter for the 9-bit-ISA core: start/ack handshake,
// PC stepping with signed relative branches, program entry table and cycle watchdog.
module run_sequencer #(
    parameter int PC_W       = 10,
    parameter int IMM_W      = 8,
    parameter int PROG_COUNT = 4,
    parameter int WDOG_LIMIT = 4096,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(PROG_COUNT)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [SEL_W-1:0] prog_sel,
    input  logic             entry_wr_en,
    input  logic [SEL_W-1:0] entry_wr_idx,
    input  logic [PC_W-1:0]  entry_wr_addr,
    input  logic             done_in,
    input  logic             branch_taken,
    input  logic [IMM_W-1:0] branch_offset,
    input  logic             stall,
    output logic [PC_W-1:0]  pc,
    output logic             run_en,
    output logic             ack,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    // Handshake: start is a level. Its rising observation arms a run and latches
    // prog_sel; its fall launches the run. ack rises when the run ends and stays
    // high until start is raised again for the next run.
    typedef enum logic [1:0] {IDLE, ARMED, RUN, FINISH} state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             timeout_q, timeout_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [PC_W-1:0]  entry_q [PROG_COUNT];

    logic [SEL_W-1:0] sel_in;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_br;
    logic             wdog_hit;
    logic             table_open;

    // Out-of-range selects (only possible for non-power-of-2 counts) fall back to slot 0.
    assign sel_in     = (32'(prog_sel) < PROG_COUNT) ? prog_sel : '0;
    assign pc_inc     = pc_q + PC_W'(1);
    assign pc_br      = pc_q + PC_W'(1) + PC_W'($signed(branch_offset));
    assign wdog_hit   = (cnt_q == CNT_W'(WDOG_LIMIT - 1));
    assign table_open = (state_q == IDLE) || (state_q == FINISH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
            sel_q     <= sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        ack_d     = ack_q;
        timeout_d = timeout_q;
        sel_d     = sel_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARMED;
                    sel_d   = sel_in;
                end
            end
            ARMED: begin
                if (!start) begin
                    state_d   = RUN;
                    pc_d      = entry_q[sel_q];
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done_in) begin
                    // The DONE instruction keeps its own address visible for readout.
                    state_d = FINISH;
                    ack_d   = 1'b1;
                end else begin
                    if (stall) begin
                        pc_d = pc_q;
                    end else if (branch_taken) begin
                        pc_d = pc_br;
                    end else begin
                        pc_d = pc_inc;
                    end
                    if (wdog_hit) begin
                        state_d   = FINISH;
                        ack_d     = 1'b1;
                        timeout_d = 1'b1;
                        cnt_d     = cnt_q;
                    end
                end
            end
            FINISH: begin
                if (start) begin
                    state_d = ARMED;
                    ack_d   = 1'b0;
                    sel_d   = sel_in;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Entry points can only change while no run is pending or active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PROG_COUNT; i++) begin
                entry_q[i] <= '0;
            end
        end else if (entry_wr_en && table_open && (32'(entry_wr_idx) < PROG_COUNT)) begin
            entry_q[entry_wr_idx] <= entry_wr_addr;
        end
    end

    assign pc          = pc_q;
    assign run_en      = (state_q == RUN);
    assign ack         = ack_q;
    assign timeout     = timeout_q;
    assign cycle_count = cnt_q;

endmodule
